// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetch PC, request FSM (IDLE/WAIT/DROP) and a two-entry
// instruction FIFO feeding the controller, with branch redirect and flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master imem,
  output logic [31:0]  Instr,
  output logic         InstrValid,
  input  logic         InstrReady,
  output logic [31:0]  PCPlus8,
  input  logic         PCSrc,
  input  logic [31:0]  BranchTarget
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t      state;
  logic [31:0] fpc;
  logic [1:0]  count;
  logic [31:0] instr0, instr1;
  // Entries keep address+8 so the head drives PCPlus8 directly and reads 0 in reset.
  logic [31:0] pc8_0, pc8_1;

  logic        ack;
  logic        pop;
  logic        redirect;
  logic        push;
  logic [31:0] new_pc8;

  assign imem.imem_addr = fpc;
  // Gated by reset so no request is presented until reset is released.
  assign imem.imem_req  = reset & ((state != IDLE) | (count != 2'd2));

  assign ack        = imem.imem_req & imem.imem_ack;
  assign InstrValid = (count != 2'd0);
  assign Instr      = instr0;
  assign PCPlus8    = pc8_0;
  assign pop        = InstrValid & InstrReady;
  assign redirect   = pop & PCSrc;
  assign new_pc8    = fpc + 32'd8;

  always_comb begin
    push = 1'b0;
    if (ack && !redirect && (state == IDLE || state == WAIT))
      push = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      fpc    <= RESET_PC;
      count  <= '0;
      instr0 <= '0;
      instr1 <= '0;
      pc8_0  <= '0;
      pc8_1  <= '0;
    end else if (redirect) begin
      // Flush wins over any push; an unanswered request must have its data dropped.
      fpc   <= BranchTarget & ~32'h3;
      count <= '0;
      state <= (imem.imem_req && !imem.imem_ack) ? DROP : IDLE;
    end else begin
      unique case (state)
        IDLE:    if (imem.imem_req && !imem.imem_ack) state <= WAIT;
        WAIT:    if (imem.imem_ack) state <= IDLE;
        DROP:    if (imem.imem_ack) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (push)
        fpc <= fpc + 32'd4;

      if (push && pop) begin
        if (count == 2'd1) begin
          instr0 <= imem.imem_rdata;
          pc8_0  <= new_pc8;
        end else begin
          instr0 <= instr1;
          pc8_0  <= pc8_1;
          instr1 <= imem.imem_rdata;
          pc8_1  <= new_pc8;
        end
      end else if (push) begin
        if (count == 2'd0) begin
          instr0 <= imem.imem_rdata;
          pc8_0  <= new_pc8;
        end else begin
          instr1 <= imem.imem_rdata;
          pc8_1  <= new_pc8;
        end
        count <= count + 2'd1;
      end else if (pop) begin
        instr0 <= instr1;
        pc8_0  <= pc8_1;
        count  <= count - 2'd1;
      end
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
    push |-> (count != 2'd2));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: streaming, backpressure, slow memory,
// redirect/drop, address wrap and reset during an outstanding request.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] PCPlus8;
  logic        PCSrc;
  logic [31:0] BranchTarget;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem         (bus.master),
    .Instr        (Instr),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .PCPlus8      (PCPlus8),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget)
  );

  always #5 clk = ~clk;

  // Memory image: word at address A reads as E000_0000 | A.
  always_comb bus.imem_rdata = 32'hE000_0000 | bus.imem_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; bus.imem_ack = 1'b0; InstrReady = 1'b0; PCSrc = 1'b0; BranchTarget = '0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.imem_ack = 1'b0; InstrReady = 1'b0; PCSrc = 1'b0; BranchTarget = '0;
    tick();
    checks++; if (InstrValid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", InstrValid); end
    checks++; if (Instr !== 32'h0) begin fails++; $display("FAIL reset_instr got %h want 00000000", Instr); end
    checks++; if (PCPlus8 !== 32'h0) begin fails++; $display("FAIL reset_pcplus8 got %h want 00000000", PCPlus8); end
    checks++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", bus.imem_req); end
    reset = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1) begin fails++; $display("FAIL release_req got %b want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin fails++; $display("FAIL release_addr got %h want 00000000", bus.imem_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    bus.imem_ack = 1'b1; InstrReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (bus.imem_addr !== 32'(4*(i+1))) begin fails++; $display("FAIL stream_addr[%0d] got %h want %h", i, bus.imem_addr, 32'(4*(i+1))); end
      checks++; if (InstrValid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d] got %b want 1", i, InstrValid); end
      checks++; if (Instr !== (32'hE000_0000 | 32'(4*i))) begin fails++; $display("FAIL stream_instr[%0d] got %h want %h", i, Instr, 32'hE000_0000 | 32'(4*i)); end
      checks++; if (PCPlus8 !== 32'(4*i+8)) begin fails++; $display("FAIL stream_pcplus8[%0d] got %h want %h", i, PCPlus8, 32'(4*i+8)); end
    end
  endtask

  task automatic test_fill();
    do_reset();
    bus.imem_ack = 1'b1; InstrReady = 1'b0;
    tick();
    checks++; if (bus.imem_req !== 1'b1) begin fails++; $display("FAIL fill1_req got %b want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h4) begin fails++; $display("FAIL fill1_addr got %h want 00000004", bus.imem_addr); end
    tick();
    checks++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL fill2_req got %b want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h8) begin fails++; $display("FAIL fill2_addr got %h want 00000008", bus.imem_addr); end
    tick();
    checks++; if (bus.imem_addr !== 32'h8) begin fails++; $display("FAIL full_addr got %h want 00000008", bus.imem_addr); end
    checks++; if (Instr !== 32'hE000_0000) begin fails++; $display("FAIL full_instr got %h want e0000000", Instr); end
    InstrReady = 1'b1;
    tick();
    checks++; if (Instr !== 32'hE000_0004) begin fails++; $display("FAIL drain1_instr got %h want e0000004", Instr); end
    checks++; if (bus.imem_req !== 1'b1) begin fails++; $display("FAIL drain1_req got %b want 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h8) begin fails++; $display("FAIL drain1_addr got %h want 00000008", bus.imem_addr); end
    tick();
    checks++; if (Instr !== 32'hE000_0008) begin fails++; $display("FAIL drain2_instr got %h want e0000008", Instr); end
    checks++; if (PCPlus8 !== 32'h10) begin fails++; $display("FAIL drain2_pcplus8 got %h want 00000010", PCPlus8); end
    checks++; if (bus.imem_addr !== 32'hC) begin fails++; $display("FAIL drain2_addr got %h want 0000000c", bus.imem_addr); end
  endtask

  task automatic test_latency();
    do_reset();
    InstrReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.imem_ack = 1'b0;
      for (int w = 0; w < 3; w++) begin
        tick();
        checks++; if (bus.imem_addr !== 32'(4*k)) begin fails++; $display("FAIL slow_addr[%0d,%0d] got %h want %h", k, w, bus.imem_addr, 32'(4*k)); end
        checks++; if (bus.imem_req !== 1'b1) begin fails++; $display("FAIL slow_req[%0d,%0d] got %b want 1", k, w, bus.imem_req); end
        checks++; if (InstrValid !== 1'b0) begin fails++; $display("FAIL slow_valid[%0d,%0d] got %b want 0", k, w, InstrValid); end
      end
      bus.imem_ack = 1'b1;
      tick();
      checks++; if (InstrValid !== 1'b1) begin fails++; $display("FAIL slow_ackvalid[%0d] got %b want 1", k, InstrValid); end
      checks++; if (Instr !== (32'hE000_0000 | 32'(4*k))) begin fails++; $display("FAIL slow_instr[%0d] got %h want %h", k, Instr, 32'hE000_0000 | 32'(4*k)); end
      checks++; if (bus.imem_addr !== 32'(4*k+4)) begin fails++; $display("FAIL slow_next[%0d] got %h want %h", k, bus.imem_addr, 32'(4*k+4)); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.imem_ack = 1'b1; InstrReady = 1'b0;
    tick();
    InstrReady = 1'b1;
    tick();
    tick();
    checks++; if (Instr !== 32'hE000_0008) begin fails++; $display("FAIL redir_head got %h want e0000008", Instr); end
    bus.imem_ack = 1'b0; InstrReady = 1'b0;
    tick();
    checks++; if (bus.imem_addr !== 32'hC) begin fails++; $display("FAIL redir_wait_addr got %h want 0000000c", bus.imem_addr); end
    InstrReady = 1'b1; PCSrc = 1'b1; BranchTarget = 32'h100;
    tick();
    PCSrc = 1'b0; InstrReady = 1'b1;
    checks++; if (InstrValid !== 1'b0) begin fails++; $display("FAIL redir_flush got %b want 0", InstrValid); end
    checks++; if (bus.imem_addr !== 32'h100) begin fails++; $display("FAIL redir_addr got %h want 00000100", bus.imem_addr); end
    checks++; if (bus.imem_req !== 1'b1) begin fails++; $display("FAIL redir_req got %b want 1", bus.imem_req); end
    bus.imem_ack = 1'b1;
    tick();
    checks++; if (InstrValid !== 1'b0) begin fails++; $display("FAIL drop_valid got %b want 0", InstrValid); end
    checks++; if (bus.imem_addr !== 32'h100) begin fails++; $display("FAIL drop_addr got %h want 00000100", bus.imem_addr); end
    tick();
    checks++; if (InstrValid !== 1'b1) begin fails++; $display("FAIL target_valid got %b want 1", InstrValid); end
    checks++; if (Instr !== 32'hE000_0100) begin fails++; $display("FAIL target_instr got %h want e0000100", Instr); end
    checks++; if (PCPlus8 !== 32'h108) begin fails++; $display("FAIL target_pcplus8 got %h want 00000108", PCPlus8); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.imem_ack = 1'b1; InstrReady = 1'b1;
    tick();
    PCSrc = 1'b1; BranchTarget = 32'h203;
    tick();
    checks++; if (InstrValid !== 1'b0) begin fails++; $display("FAIL align_flush got %b want 0", InstrValid); end
    checks++; if (bus.imem_addr !== 32'h200) begin fails++; $display("FAIL align_addr got %h want 00000200", bus.imem_addr); end
    PCSrc = 1'b0;
    tick();
    PCSrc = 1'b1; BranchTarget = 32'hFFFF_FFFF;
    tick();
    checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL top_addr got %h want fffffffc", bus.imem_addr); end
    PCSrc = 1'b0;
    tick();
    checks++; if (bus.imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr got %h want 00000000", bus.imem_addr); end
    checks++; if (Instr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_instr got %h want fffffffc", Instr); end
    checks++; if (PCPlus8 !== 32'h4) begin fails++; $display("FAIL wrap_pcplus8 got %h want 00000004", PCPlus8); end
    // PCSrc without a pop must not redirect.
    PCSrc = 1'b1; BranchTarget = 32'h400; InstrReady = 1'b0;
    tick();
    checks++; if (bus.imem_addr !== 32'h4) begin fails++; $display("FAIL nopop_addr got %h want 00000004", bus.imem_addr); end
    checks++; if (Instr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL nopop_instr got %h want fffffffc", Instr); end
    PCSrc = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.imem_ack = 1'b1; InstrReady = 1'b0;
    tick();
    bus.imem_ack = 1'b0;
    tick();
    checks++; if (bus.imem_addr !== 32'h4) begin fails++; $display("FAIL mid_wait_addr got %h want 00000004", bus.imem_addr); end
    reset = 1'b0;
    #1;
    checks++; if (InstrValid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b want 0", InstrValid); end
    checks++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL mid_req got %b want 0", bus.imem_req); end
    bus.imem_ack = 1'b1;
    tick();
    checks++; if (InstrValid !== 1'b0) begin fails++; $display("FAIL mid_ackvalid got %b want 0", InstrValid); end
    bus.imem_ack = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (bus.imem_addr !== 32'h0) begin fails++; $display("FAIL mid_restart_addr got %h want 00000000", bus.imem_addr); end
    checks++; if (bus.imem_req !== 1'b1) begin fails++; $display("FAIL mid_restart_req got %b want 1", bus.imem_req); end
    bus.imem_ack = 1'b1;
    tick();
    checks++; if (Instr !== 32'hE000_0000) begin fails++; $display("FAIL mid_first_instr got %h want e0000000", Instr); end
    checks++; if (PCPlus8 !== 32'h8) begin fails++; $display("FAIL mid_first_pcplus8 got %h want 00000008", PCPlus8); end
  endtask

  initial begin
    reset = 1'b0; bus.imem_ack = 1'b0; InstrReady = 1'b0; PCSrc = 1'b0; BranchTarget = '0;
    test_reset();
    test_stream();
    test_fill();
    test_latency();
    test_redirect();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
